// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the serial datapath blocks.
package arith_pkg;

  // Default operand width for serial arithmetic engines.
  localparam int SERIAL_WIDTH = 8;

  // Sequencer states for the bit-serial engines.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder.
interface serial_adder_if #(
  parameter int WIDTH = arith_pkg::SERIAL_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Requester side: issues operands, observes status and result.
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  // Engine side: accepts operands, drives status and result.
  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/full_adder_cell.sv
// One-bit full adder; the additive mirror of the full-subtractor cell.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum is the three-way parity; carry is generate or propagate-with-carry.
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell plus a carry flop,
// one sum bit per clock, result published with a one-cycle done pulse.
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_s;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt;

  logic             bit_s;
  logic             bit_co;
  logic [WIDTH-1:0] sh_s_next;

  // The single arithmetic cell, fed by the operand LSBs and the carry flop.
  full_adder_cell u_fa (
    .x  (sh_a[0]),
    .y  (sh_b[0]),
    .ci (carry),
    .s  (bit_s),
    .co (bit_co)
  );

  // Sum shift register after this cycle's bit enters at the MSB; on the
  // last bit this is the complete result, so it is latched directly.
  assign sh_s_next = {bit_s, sh_s[WIDTH-1:1]};

  // Sequencer, operand/sum shifters, carry flop and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all of them sample the values
    // from before this edge; mixing in = would make order inside the block
    // change behaviour and diverge between simulation and hardware.
    if (rst) begin
      state  <= IDLE;
      sh_a   <= '0;
      sh_b   <= '0;
      sh_s   <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
      cnt    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sh_a  <= bus.a;
            sh_b  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= bit_co;
          sh_s  <= sh_s_next;
          sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            sum_q  <= sh_s_next;
            cout_q <= bit_co;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status decoded from registered state; result straight from its flops.
  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases, random
// operands against an arithmetic reference, and a full WIDTH=2 sweep.
module tb_serial_adder;
  import arith_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(2)) bus2 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  int vectors = 0;
  int errors  = 0;

  // Last published results, used to prove outputs never show partials.
  logic [7:0] last8_sum;
  logic       last8_cout;
  logic [1:0] last2_sum;
  logic       last2_cout;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation started from IDLE; checks busy, latency,
  // stability of the old result during the run, the result, and that
  // done is a single pulse. Operands are scrambled after acceptance.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic c, input string tag);
    logic [8:0] expv;
    int         lat;
    bit         seen;
    expv = 9'(a) + 9'(b) + 9'(c);
    bus8.a = a; bus8.b = b; bus8.cin = c; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
    vectors++;
    if (bus8.busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_start: got %b expected 1", tag, bus8.busy);
    end
    lat = 1; seen = 0;
    while (!seen && lat < 16) begin
      tick();
      lat++;
      if (bus8.done === 1'b1) seen = 1;
      else begin
        vectors++;
        if (bus8.sum !== last8_sum || bus8.cout !== last8_cout) begin
          errors++;
          $display("FAIL %s partial_result: got %b/%h expected %b/%h", tag,
                   bus8.cout, bus8.sum, last8_cout, last8_sum);
        end
      end
    end
    vectors++;
    if (!seen) begin
      errors++; $display("FAIL %s done_timeout: got no done in %0d cycles expected 9", tag, lat);
    end else begin
      if (lat != 9) begin
        errors++; $display("FAIL %s latency: got %0d expected 9", tag, lat);
      end
      vectors++;
      if ({bus8.cout, bus8.sum} !== expv) begin
        errors++; $display("FAIL %s result: got %b/%h expected %b/%h", tag,
                           bus8.cout, bus8.sum, expv[8], expv[7:0]);
      end
    end
    last8_sum = expv[7:0]; last8_cout = expv[8];
    tick();
    vectors++;
    if (bus8.done !== 1'b0 || bus8.busy !== 1'b0 || {bus8.cout, bus8.sum} !== expv) begin
      errors++; $display("FAIL %s after_done: got done=%b busy=%b %b/%h expected done=0 busy=0 %b/%h",
                         tag, bus8.done, bus8.busy, bus8.cout, bus8.sum, expv[8], expv[7:0]);
    end
  endtask

  // Same sequence for the WIDTH=2 instance; done expected 3 edges in.
  task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic c);
    logic [2:0] expv;
    int         lat;
    bit         seen;
    expv = 3'(a) + 3'(b) + 3'(c);
    bus2.a = a; bus2.b = b; bus2.cin = c; bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    bus2.a = 2'($urandom); bus2.b = 2'($urandom); bus2.cin = 1'($urandom);
    lat = 1; seen = 0;
    while (!seen && lat < 8) begin
      tick();
      lat++;
      if (bus2.done === 1'b1) seen = 1;
      else begin
        vectors++;
        if (bus2.sum !== last2_sum || bus2.cout !== last2_cout) begin
          errors++; $display("FAIL w2 partial_result a=%h b=%h c=%b: got %b/%h expected %b/%h",
                             a, b, c, bus2.cout, bus2.sum, last2_cout, last2_sum);
        end
      end
    end
    vectors++;
    if (!seen || lat != 3 || {bus2.cout, bus2.sum} !== expv) begin
      errors++; $display("FAIL w2 a=%h b=%h c=%b: got seen=%0d lat=%0d %b/%h expected lat=3 %b/%h",
                         a, b, c, seen, lat, bus2.cout, bus2.sum, expv[2], expv[1:0]);
    end
    last2_sum = expv[1:0]; last2_cout = expv[2];
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== 11'b0 ||
        {bus2.busy, bus2.done, bus2.cout, bus2.sum} !== 5'b0) begin
      errors++; $display("FAIL reset_state: got w8 %b%b%b/%h w2 %b%b%b/%h expected all 0",
                         bus8.busy, bus8.done, bus8.cout, bus8.sum,
                         bus2.busy, bus2.done, bus2.cout, bus2.sum);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (bus8.busy !== 1'b0 || bus2.busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got busy %b/%b expected 0/0", bus8.busy, bus2.busy);
    end
    last8_sum = '0; last8_cout = 1'b0;
    last2_sum = '0; last2_cout = 1'b0;
  endtask

  task automatic test_basic();
    run8(8'h35, 8'h4A, 1'b0, "basic");
  endtask

  task automatic test_carry_ripple();
    run8(8'hFF, 8'h00, 1'b1, "ripple_ff_00");
    run8(8'hFF, 8'hFF, 1'b1, "ripple_ff_ff");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), "random");
  endtask

  // A start during RUN must be dropped: one done, result of first pair.
  task automatic test_busy_ignore();
    int  lat;
    int  dones;
    bit  seen;
    bus8.a = 8'h01; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    repeat (3) tick();
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    lat = 5; seen = 0;
    while (!seen && lat < 16) begin
      tick();
      lat++;
      if (bus8.done === 1'b1) seen = 1;
    end
    vectors++;
    if (!seen || lat != 9 || {bus8.cout, bus8.sum} !== 9'h002) begin
      errors++; $display("FAIL busy_ignore: got seen=%0d lat=%0d %b/%h expected lat=9 0/02",
                         seen, lat, bus8.cout, bus8.sum);
    end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus8.done === 1'b1) dones++;
      vectors++;
      if ({bus8.cout, bus8.sum} !== 9'h002) begin
        errors++; $display("FAIL busy_ignore_hold: got %b/%h expected 0/02", bus8.cout, bus8.sum);
      end
    end
    vectors++;
    if (dones != 0) begin
      errors++; $display("FAIL busy_ignore_extra_done: got %0d expected 0", dones);
    end
    last8_sum = 8'h02; last8_cout = 1'b0;
  endtask

  // run8 leaves the bench in the IDLE cycle right after done, so the
  // second call asserts start in exactly that cycle.
  task automatic test_back_to_back();
    run8(8'($urandom), 8'($urandom), 1'($urandom), "b2b_first");
    run8(8'h10, 8'h20, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_mid_run();
    int dones;
    bus8.a = 8'hF0; bus8.b = 8'h0F; bus8.cin = 1'b0; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== 11'b0) begin
      errors++; $display("FAIL reset_mid_run: got busy=%b done=%b %b/%h expected all 0",
                         bus8.busy, bus8.done, bus8.cout, bus8.sum);
    end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0) begin
      errors++; $display("FAIL reset_no_done: got %0d active cycles expected 0", dones);
    end
    last8_sum = '0; last8_cout = 1'b0;
    last2_sum = '0; last2_cout = 1'b0;
  endtask

  task automatic test_sweep_w2();
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++)
          run2(2'(a), 2'(b), 1'(c));
  endtask

  initial begin
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
    test_reset();
    test_basic();
    test_carry_ripple();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep_w2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, LSB-first ripple adder; the additive counterpart of the team's full-subtractor cell.
- Loads two WIDTH-bit operands and a carry-in on a start pulse.
- Computes one sum bit per clock through a single full-adder cell and a carry flip-flop.
- Presents the registered WIDTH-bit sum and carry-out with a one-cycle done pulse.
- Intended as the low-area arithmetic engine for serial datapaths elsewhere in the design.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepted start.
- b  input  WIDTH  operand B; sampled on the accepted start.
- cin  input  1  carry-in; sampled on the accepted start.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle.
- sum  output  WIDTH  registered result (a + b + cin) mod 2^WIDTH.
- cout  output  1  registered carry-out of the MSB.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high. All state changes occur only on the rising edge of clk.
- Reset values: state=IDLE; busy=0, done=0, sum=0, cout=0. Internal shift registers, carry flip-flop and bit counter are all 0.
- Reset mid-operation aborts the operation. The next cycle is IDLE with all outputs 0, and no done pulse is issued for the aborted operation.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1, load shA<=a, shB<=b, carry<=cin, cnt<=0 and move to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - s = shA[0]^shB[0]^carry.
  - carry <= (shA[0]&shB[0]) | (carry&(shA[0]^shB[0])).
  - shS <= {s, shS[WIDTH-1:1]}.
  - shA and shB shift right with zero fill.
  - cnt <= cnt+1.
  - On the cycle where cnt==WIDTH-1, also latch sum <= {s, shS[WIDTH-1:1]} and cout <= new carry, then move to DONE.
- DONE: done=1 for exactly this cycle, then unconditionally return to IDLE.
- start is ignored in RUN and DONE, with no queuing. start in the cycle after done (IDLE) is accepted.
- Latency: start accepted at edge N, done high during cycle N+WIDTH+1, so the minimum issue interval is WIDTH+2 cycles.
- sum/cout remain stable from the done cycle until the next completion or reset. They never show partial results.
- busy = (state != IDLE), decoded from registered state.
- Counter width is $clog2(WIDTH). The count wraps only via reload in IDLE.
- The operand inputs a, b and cin may change freely after the accepted start without affecting the result.

Decomposition:
- Shared package arith_pkg holds:
  - the state enum (IDLE, RUN, DONE) with a 2-bit encoding;
  - the default width constant SERIAL_WIDTH=8.
- One combinational sub-module, full_adder_cell (inputs x, y, ci; outputs s, co), instantiated once for the per-bit sum/carry. It is the additive mirror of the existing full-subtractor cell.
- FSM, counter and shift registers live in serial_adder.

Test Plan:
- Basic add: WIDTH=8, a=8'h35, b=8'h4A, cin=0, start for 1 cycle -> busy=1 on next cycle; done pulses exactly 9 cycles after the start edge; sum=8'h7F, cout=0.
- Full carry ripple: a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Busy ignore: start a=8'h01, b=8'h01; pulse start with a=8'hAA mid-RUN -> only one done, sum=8'h02; sum/cout do not change until the next done.
- Back-to-back: assert start the cycle after done with a=8'h10, b=8'h20, cin=0 -> accepted; second done after 9 more cycles; sum=8'h30. Operands changed after the start edge have no effect.
- Reset mid-run: start a=8'hF0, b=8'h0F; assert rst at cycle 4 of RUN -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse follows.
- Exhaustive WIDTH=2 sweep: all 32 combinations of a, b and cin -> {cout, sum} == a+b+cin for every case, each done 3 cycles after start.
